// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton.
// Boundary and FSM encodings plus the virtual-neighbour helper.
package eca_pkg;

    typedef enum logic [1:0] {
        BND_ZERO    = 2'b00,
        BND_ONE     = 2'b01,
        BND_WRAP    = 2'b10,
        BND_REFLECT = 2'b11
    } bnd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_e;

    localparam logic [7:0] RULE_110 = 8'd110;

    // Returns {cell[N], cell[-1]} for the given edge mode.
    function automatic logic [1:0] virt_nbrs(
        bnd_e mode,
        logic c_first,
        logic c_last
    );
        logic [1:0] v;
        unique case (mode)
            BND_ZERO:    v = 2'b00;
            BND_ONE:     v = 2'b11;
            BND_WRAP:    v = {c_first, c_last};
            BND_REFLECT: v = {c_last, c_first};
            default:     v = 2'b00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/eca_if.sv
// Config, block-port and stepping bundle between the pin wrapper
// and the automaton core.
interface eca_if #(
    parameter int NUM_CELLS = 240,
    parameter int BLOCK_W = 8,
    parameter int ADDR_W =
        $clog2((NUM_CELLS + BLOCK_W - 1) / BLOCK_W),
    parameter int GEN_W = 16
);

    logic              cfg_we;
    logic [7:0]        rule_in;
    logic [1:0]        boundary_in;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0] wr_data;
    logic [BLOCK_W-1:0] rd_data;
    logic              run;
    logic              step_start;
    logic [GEN_W-1:0]  step_n;
    logic              busy;
    logic [GEN_W-1:0]  gen_count;

    modport master (
        output cfg_we,
        output rule_in,
        output boundary_in,
        output wr_en,
        output addr,
        output wr_data,
        output run,
        output step_start,
        output step_n,
        input  rd_data,
        input  busy,
        input  gen_count
    );

    modport slave (
        input  cfg_we,
        input  rule_in,
        input  boundary_in,
        input  wr_en,
        input  addr,
        input  wr_data,
        input  run,
        input  step_start,
        input  step_n,
        output rd_data,
        output busy,
        output gen_count
    );

endinterface

// File: rtl/eca_cell.sv
// One automaton cell: next state is the rule bit selected by
// the {left, centre, right} neighbourhood.
module eca_cell (
    input  logic [7:0] rule,
    input  logic       l,
    input  logic       c,
    input  logic       r,
    output logic       nxt
);

    assign nxt = rule[{l, c, r}];

endmodule

// File: rtl/eca_core.sv
// Elementary cellular automaton engine: loadable rule, edge modes,
// free-run and counted bursts, and a block read/write port.
module eca_core
    import eca_pkg::*;
#(
    parameter int NUM_CELLS = 240,
    parameter int BLOCK_W = 8,
    parameter int ADDR_W =
        $clog2((NUM_CELLS + BLOCK_W - 1) / BLOCK_W),
    parameter int GEN_W = 16,
    parameter logic [7:0] DEFAULT_RULE = RULE_110
) (
    input logic  clk,
    input logic  rst_n,
    eca_if.slave bus
);

    localparam int NBLK = (NUM_CELLS + BLOCK_W - 1) / BLOCK_W;
    localparam int PADW = NBLK * BLOCK_W;
    localparam logic [NUM_CELLS-1:0] CELLS_RST =
        {{(NUM_CELLS-1){1'b0}}, 1'b1};

    logic [NUM_CELLS-1:0] cells;
    logic [NUM_CELLS-1:0] cells_d;
    logic [NUM_CELLS-1:0] nxt;
    logic [NUM_CELLS+1:0] ext;
    logic [1:0]           vn;
    logic [7:0]           rule;
    bnd_e                 bnd;
    state_e               state;
    logic                 busy_q;
    logic [GEN_W-1:0]     burst_cnt;
    logic [GEN_W-1:0]     gen_cnt;
    logic                 start_ok;
    logic                 adv;
    logic [PADW-1:0]      pad;
    logic [NBLK-1:0]      wr_hit;
    logic [BLOCK_W-1:0]   blk [NBLK];

    // A burst can only be armed from a non-burst state.
    assign start_ok = bus.step_start
                    && (bus.step_n != '0)
                    && (state != S_BURST);

    assign adv = !bus.wr_en
               && ((state == S_BURST)
                   || (bus.run && !start_ok));

    assign vn  = virt_nbrs(bnd, cells[0], cells[NUM_CELLS-1]);
    assign ext = {vn[1], cells, vn[0]};

    // ext[i+1] is cell i; ext[0] and ext[N+1] are the virtual cells.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        localparam int B = i / BLOCK_W;
        localparam int K = i % BLOCK_W;

        eca_cell u_cell (
            .rule (rule),
            .l    (ext[i+2]),
            .c    (ext[i+1]),
            .r    (ext[i]),
            .nxt  (nxt[i])
        );

        assign cells_d[i] = wr_hit[B] ? bus.wr_data[K]
                          : adv       ? nxt[i]
                          :             cells[i];
    end

    assign pad = PADW'(cells);

    for (genvar b = 0; b < NBLK; b++) begin : g_blk
        assign blk[b]    = pad[b*BLOCK_W +: BLOCK_W];
        assign wr_hit[b] = bus.wr_en
                        && (bus.addr == ADDR_W'(b));
    end

    always_comb begin
        bus.rd_data = '0;
        if (32'(bus.addr) < NBLK) begin
            bus.rd_data = blk[bus.addr];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.gen_count = gen_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells     <= CELLS_RST;
            rule      <= DEFAULT_RULE;
            bnd       <= BND_ZERO;
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            burst_cnt <= '0;
            gen_cnt   <= '0;
        end else begin
            cells <= cells_d;

            if (bus.cfg_we) begin
                rule <= bus.rule_in;
                bnd  <= bnd_e'(bus.boundary_in);
            end

            if (adv) begin
                gen_cnt <= gen_cnt + 1'b1;
            end

            unique case (state)
                S_IDLE, S_RUN: begin
                    if (start_ok) begin
                        state     <= S_BURST;
                        busy_q    <= 1'b1;
                        burst_cnt <= bus.step_n;
                    end else begin
                        state <= bus.run ? S_RUN : S_IDLE;
                    end
                end
                S_BURST: begin
                    if (adv) begin
                        burst_cnt <= burst_cnt - 1'b1;
                        if (burst_cnt == GEN_W'(1)) begin
                            busy_q <= 1'b0;
                            state  <= bus.run ? S_RUN : S_IDLE;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eca_core.sv
// Scoreboard bench for eca_core: a minterm-based reference model
// queues expected block/counter values, DUT reads pop and compare.
module tb_eca_core;
    import eca_pkg::*;

    localparam int NC = 240;
    localparam int BW = 8;
    localparam int NB = 30;
    localparam int AW = $clog2(NB);
    localparam int GW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #100 clk = ~clk;

    eca_if #(
        .NUM_CELLS (NC),
        .BLOCK_W   (BW),
        .ADDR_W    (AW),
        .GEN_W     (GW)
    ) bus ();

    eca_core #(
        .NUM_CELLS    (NC),
        .BLOCK_W      (BW),
        .ADDR_W       (AW),
        .GEN_W        (GW),
        .DEFAULT_RULE (8'd110)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sb_q[$];
    string       sb_t[$];

    logic [NC-1:0] m_cells;
    logic [7:0]    m_rule;
    logic [1:0]    m_bnd;
    int unsigned   m_gen;
    logic          m_busy;
    int unsigned   m_cnt;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic sb_push(string tag, logic [31:0] v);
        sb_t.push_back(tag);
        sb_q.push_back(v);
    endtask

    task automatic sb_pop(logic [31:0] got);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            chk(sb_t.pop_front(), got, sb_q.pop_front());
        end
    endtask

    function automatic logic [7:0] m_blk(int a);
        return 8'(m_cells >> (a * BW));
    endfunction

    function automatic logic [NC-1:0] m_step(
        logic [NC-1:0] c, logic [7:0] r, logic [1:0] b);
        logic hi, lo;
        logic [NC-1:0] lv, rv, n, t;
        case (b)
            2'b00:   begin hi = 1'b0;    lo = 1'b0;    end
            2'b01:   begin hi = 1'b1;    lo = 1'b1;    end
            2'b10:   begin hi = c[0];    lo = c[NC-1]; end
            default: begin hi = c[NC-1]; lo = c[0];    end
        endcase
        lv = {hi, c[NC-1:1]};
        rv = {c[NC-2:0], lo};
        n = '0;
        for (int p = 0; p < 8; p++) begin
            if (((r >> p) & 8'd1) != 8'd0) begin
                t = (p[2] ? lv : ~lv)
                  & (p[1] ? c  : ~c)
                  & (p[0] ? rv : ~rv);
                n = n | t;
            end
        end
        return n;
    endfunction

    task automatic m_reset();
        m_cells = NC'(1);
        m_rule  = 8'd110;
        m_bnd   = 2'b00;
        m_gen   = 0;
        m_busy  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic tick();
        logic [NC-1:0] nc, msk;
        logic adv, st, nb;
        int unsigned nk, ng, sh;
        logic [7:0] nr;
        logic [1:0] nbd;
        st  = bus.step_start && (bus.step_n != 0) && !m_busy;
        adv = !bus.wr_en && (m_busy || (bus.run && !st));
        nc = m_cells;
        nb = m_busy;
        nk = m_cnt;
        ng = m_gen;
        if (bus.wr_en) begin
            sh  = 32'(bus.addr) * BW;
            msk = NC'(8'hFF) << sh;
            nc  = (nc & ~msk) | (NC'(bus.wr_data) << sh);
        end else if (adv) begin
            nc = m_step(m_cells, m_rule, m_bnd);
        end
        if (adv) begin
            ng = (m_gen + 1) & 32'hFFFF;
            if (m_busy) begin
                nk = m_cnt - 1;
                if (nk == 0) nb = 1'b0;
            end
        end
        if (st) begin
            nb = 1'b1;
            nk = 32'(bus.step_n);
        end
        nr  = bus.cfg_we ? bus.rule_in : m_rule;
        nbd = bus.cfg_we ? bus.boundary_in : m_bnd;
        @(posedge clk);
        #1;
        m_cells = nc;
        m_busy  = nb;
        m_cnt   = nk;
        m_gen   = ng;
        m_rule  = nr;
        m_bnd   = nbd;
    endtask

    task automatic look(int a);
        bus.addr = AW'(a);
        #1;
        sb_pop(32'(bus.rd_data));
    endtask

    task automatic see_all(string tag);
        for (int a = 0; a < NB; a++) begin
            sb_push($sformatf("%s_b%0d", tag, a), 32'(m_blk(a)));
            look(a);
        end
    endtask

    task automatic see_st(string tag);
        sb_push({tag, "_gen"}, m_gen);
        sb_pop(32'(bus.gen_count));
        sb_push({tag, "_busy"}, 32'(m_busy));
        sb_pop(32'(bus.busy));
    endtask

    task automatic idle_in();
        bus.cfg_we      = 1'b0;
        bus.rule_in     = 8'd0;
        bus.boundary_in = 2'b00;
        bus.wr_en       = 1'b0;
        bus.addr        = '0;
        bus.wr_data     = '0;
        bus.run         = 1'b0;
        bus.step_start  = 1'b0;
        bus.step_n      = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        #3;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(int a, logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.addr    = AW'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic cfg(logic [7:0] r, logic [1:0] b);
        bus.cfg_we      = 1'b1;
        bus.rule_in     = r;
        bus.boundary_in = b;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic adv_n(int n);
        bus.run = 1'b1;
        repeat (n) tick();
        bus.run = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned g0;

        do_reset();
        see_st("rst");
        sb_push("rst_b0", 32'h01);
        look(0);
        see_all("rst");

        adv_n(1);
        sb_push("r110_b0", 32'h03);
        look(0);
        sb_push("r110_gen", 32'd1);
        sb_pop(32'(bus.gen_count));

        wr(0, 8'h00);
        wr(29, 8'h80);
        cfg(8'd110, 2'(BND_WRAP));
        adv_n(1);
        sb_push("wrap_b0", 32'h01);
        look(0);
        sb_push("wrap_b29", 32'h80);
        look(29);
        see_all("wrap");

        wr(0, 8'h00);
        wr(29, 8'h80);
        cfg(8'd110, 2'(BND_ZERO));
        adv_n(1);
        sb_push("zero_b0", 32'h00);
        look(0);
        sb_push("zero_b29", 32'h80);
        look(29);

        cfg(8'h5A, 2'(BND_ZERO));
        wr(0, 8'h00);
        wr(3, 8'h10);
        adv_n(1);
        sb_push("r90_b3", 32'h28);
        look(3);
        see_all("r90");

        cfg(8'd30, 2'(BND_REFLECT));
        wr(0, 8'h81);
        wr(29, 8'h81);
        adv_n(3);
        see_all("refl");
        cfg(8'd150, 2'(BND_ONE));
        adv_n(2);
        see_all("one");

        for (int k = 0; k < 4; k++) begin
            cfg(8'($urandom), 2'($urandom_range(0, 3)));
            for (int j = 0; j < 6; j++) begin
                wr(int'($urandom_range(0, 31)), 8'($urandom));
            end
            bus.run = 1'b1;
            bus.cfg_we = 1'b1;
            bus.rule_in = 8'($urandom);
            bus.boundary_in = 2'($urandom_range(0, 3));
            tick();
            bus.cfg_we = 1'b0;
            adv_n(int'($urandom_range(1, 4)));
            see_all($sformatf("rnd%0d", k));
            see_st($sformatf("rnd%0d", k));
        end

        do_reset();
        bus.step_n = 16'd0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        sb_push("n0_busy", 32'd0);
        sb_pop(32'(bus.busy));
        see_st("n0");

        bus.step_n = 16'd5;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 2) begin
                bus.step_start = 1'b1;
                bus.step_n = 16'd9;
            end
            tick();
            bus.step_start = 1'b0;
        end
        sb_push("b5_len", 32'd5);
        sb_pop(32'(n));
        sb_push("b5_gen", 32'd5);
        sb_pop(32'(bus.gen_count));
        tick();
        tick();
        sb_push("b5_idle_gen", 32'd5);
        sb_pop(32'(bus.gen_count));
        see_st("b5");
        see_all("b5");

        bus.step_n = 16'd4;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        g0 = m_gen;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 2) begin
                bus.wr_en = 1'b1;
                bus.addr = AW'(5);
                bus.wr_data = 8'hA5;
            end
            tick();
            bus.wr_en = 1'b0;
            if (n == 2) begin
                sb_push("bw_mid_b5", 32'hA5);
                look(5);
            end
        end
        sb_push("bw_len", 32'd5);
        sb_pop(32'(n));
        sb_push("bw_gen", (g0 + 4) & 32'hFFFF);
        sb_pop(32'(bus.gen_count));
        see_all("bw");

        bus.step_n = 16'd10;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        sb_push("ar_busy", 32'd0);
        sb_pop(32'(bus.busy));
        sb_push("ar_gen", 32'd0);
        sb_pop(32'(bus.gen_count));
        sb_push("ar_b0", 32'h01);
        look(0);
        see_all("ar");
        rst_n = 1'b1;
        tick();
        see_st("ar_post");

        wr(2, 8'h3C);
        wr(29, 8'hC3);
        sb_push("oor31", 32'h00);
        look(31);
        sb_push("oor30", 32'h00);
        look(30);
        wr(31, 8'hFF);
        sb_push("oor31_wr", 32'h00);
        look(31);
        see_all("oor");
        see_st("oor");

        if (sb_q.size() != 0) begin
            chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eca_core.md
Name: eca_core

Overview:
Parametrised elementary cellular automaton engine. Successor to the fixed rule-110 array. Adds:
- a runtime-loadable 8-bit Wolfram rule
- selectable boundary mode
- free-run and counted-burst stepping with a busy flag
- a generation counter

Sits behind the TT pin-mapping wrapper. The wrapper drives config, block-address and data buses; this core holds all cell state.

Parameters:
NUM_CELLS, 240, number of automaton cells
BLOCK_W, 8, cells per read/write block
ADDR_W, $clog2((NUM_CELLS+BLOCK_W-1)/BLOCK_W), block address width
GEN_W, 16, width of burst length and generation counter
DEFAULT_RULE, 8'd110, rule loaded at reset

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  load rule_in and boundary_in into config registers
rule_in  in  8  Wolfram rule number
boundary_in  in  2  boundary mode: 00 zero, 01 one, 10 wrap, 11 reflect
wr_en  in  1  write wr_data into block addr
addr  in  ADDR_W  block address for read and write
wr_data  in  BLOCK_W  block write data; bit k goes to cell addr*BLOCK_W+k
rd_data  out  BLOCK_W  current state of block addr, combinational
run  in  1  level: advance one generation per cycle while high
step_start  in  1  pulse: begin a burst of step_n generations
step_n  in  GEN_W  burst length, sampled on step_start
busy  out  1  burst in progress
gen_count  out  GEN_W  generations advanced since reset, wraps modulo 2^GEN_W

Behaviour:
- Reset (rst_n low, async) sets:
  - cells = 0 except cell 0 = 1
  - rule = DEFAULT_RULE, boundary = 00
  - state = IDLE, busy = 0, gen_count = 0, burst counter = 0
  - rd_data then reflects the reset cells.
- Next-state rule: next[i] = rule[{L,C,R}], where L = cell[i+1], C = cell[i], R = cell[i-1].
- Virtual neighbours cell[NUM_CELLS] and cell[-1] depend on boundary mode:
  - zero: 0
  - one: 1
  - wrap: cell[0] and cell[NUM_CELLS-1] respectively
  - reflect: cell[NUM_CELLS-1] and cell[0] respectively
- Advance: all cells update simultaneously from the current state on one edge; gen_count += 1.
- FSM states:
  - IDLE: advance when run=1.
  - RUN: entered on run=1; exit to IDLE on run=0.
  - BURST: entered from IDLE/RUN on step_start with step_n != 0. Counter loads step_n; busy=1 from the next cycle. Each advance decrements the counter. The last advance clears busy in the same edge. Then go to RUN if run=1, else IDLE.
- Burst start and ignore rules:
  - step_start with step_n=0 is ignored.
  - step_start while busy is ignored.
  - The step_start cycle itself does not advance. The first burst advance is on the following edge.
- Priority on each edge: wr_en > advance.
  - A wr_en cycle writes the block and suppresses the advance. Burst counter and gen_count hold, so the burst stretches by one cycle.
- cfg_we is independent of stepping. A new rule/boundary is used from the next edge; an advance in the same edge uses the old config.
- Out of range (addr*BLOCK_W >= NUM_CELLS):
  - rd_data = 0 and writes are ignored.
  - A partially populated last block reads 0 in missing bits; writes to missing bits are dropped.
- Reset asserted mid-burst aborts immediately into the reset state. No partial update.

Decomposition:
- Package eca_pkg holds:
  - boundary-mode enum (BND_ZERO, BND_ONE, BND_WRAP, BND_REFLECT)
  - FSM state enum (S_IDLE, S_RUN, S_BURST)
  - RULE_110 constant
- Sub-module eca_cell: combinational 3-in/1-out lookup of an 8-bit rule. Instantiated NUM_CELLS times via generate.
- FSM, counters, boundary muxing and the block read/write port stay in eca_core.

Test Plan:
- Reset, run=1 for 1 cycle, boundary zero, rule 110 → block 0 = 0x03, gen_count = 1.
- Wrap: write block 0 = 0x00, block 29 = 0x80; cfg boundary 10; one advance → block 0 = 0x01, block 29 = 0x80. Repeat with boundary 00 → block 0 = 0x00.
- Rule 90: cfg rule 0x5A; write block 0 = 0, block 3 = 0x10; one advance → block 3 = 0x28.
- Burst: after reset, step_start with step_n=5, run=0 → busy high exactly 5 cycles, gen_count = 5, FSM back to IDLE. step_start during busy is ignored.
- Write during burst: step_n=4, wr_en pulsed on 2nd busy cycle → busy lasts 5 cycles, gen_count = 4, written block reflects wr_data before the subsequent advances.
- Async reset mid-burst and out of range:
  - rst_n low asynchronously mid-burst → busy=0, gen_count=0, block 0 = 0x01 before the next clock edge.
  - addr=31 → rd_data = 0 and a write there leaves all blocks unchanged.
